// File: rtl/status_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : status_handshake_tx
// Description : Sends a DATA_WIDTH status word to the Pico over a four-phase
//               req/ack handshake. A transfer starts on a status change, a
//               send strobe (queued while busy) or an idle heartbeat. Each ack
//               edge is timed out, and an abort is followed by a holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
module status_handshake_tx #(
  parameter int DATA_WIDTH       = 4,
  parameter int SETUP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES   = 250_000,
  parameter int HEARTBEAT_CYCLES = 25_000_000
) (
  input  logic                  clk,
  input  logic                  internal_reset,
  input  logic [DATA_WIDTH-1:0] status_in,
  input  logic                  send_strobe,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic                  busy,
  output logic                  sent_pulse,
  output logic                  timeout_err
);

  // Counter widths follow each limit; the max() guard keeps a limit of 1 legal.
  localparam int c_setup_w = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int c_tmo_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_hb_w    = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

  localparam logic [c_setup_w-1:0] c_setup_last = c_setup_w'(SETUP_CYCLES - 1);
  localparam logic [c_tmo_w-1:0]   c_tmo_last   = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_hb_w-1:0]    c_hb_last    = c_hb_w'(HEARTBEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SETUP       = 3'd1,
    WAIT_ACK_HI = 3'd2,
    WAIT_ACK_LO = 3'd3,
    HOLDOFF     = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_ack_meta;
  logic                  r_ack_s;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] r_last_sent;
  logic                  r_tx_req;
  logic                  r_busy;
  logic                  r_sent_pulse;
  logic                  r_timeout_err;
  logic                  r_pending;
  logic [c_setup_w-1:0]  r_setup_cnt;
  logic [c_tmo_w-1:0]    r_tmo_cnt;
  logic [c_hb_w-1:0]     r_hb_cnt;
  logic                  w_trigger;

  // Any reason to (re)send the status word; only acted on in IDLE.
  assign w_trigger = (status_in != r_last_sent) || send_strobe || r_pending ||
                     (r_hb_cnt == c_hb_last);

  // Two-flop synchronizer: tx_ack comes from the Pico clock domain.
  always_ff @(posedge clk or posedge internal_reset) begin
    if (internal_reset) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= tx_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Handshake FSM with all outputs registered; async reset drops tx_req at once.
  always_ff @(posedge clk or posedge internal_reset) begin
    if (internal_reset) begin
      r_state       <= IDLE;
      r_tx_data     <= '0;
      r_last_sent   <= '0;
      r_tx_req      <= 1'b0;
      r_busy        <= 1'b0;
      r_sent_pulse  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_pending     <= 1'b0;
      r_setup_cnt   <= '0;
      r_tmo_cnt     <= '0;
      r_hb_cnt      <= '0;
    end else begin
      r_sent_pulse <= 1'b0;
      // A strobe that cannot start a transfer right now is remembered; any
      // number of them collapse into one flag. A start below overrides this.
      if (send_strobe) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_trigger && !r_ack_s) begin
            r_tx_data   <= status_in;
            r_state     <= SETUP;
            r_busy      <= 1'b1;
            r_pending   <= 1'b0;
            r_hb_cnt    <= '0;
            r_setup_cnt <= '0;
          end else if (r_hb_cnt != c_hb_last) begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
          end
        end

        SETUP: begin
          if (r_setup_cnt == c_setup_last) begin
            r_tx_req  <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= WAIT_ACK_HI;
          end else begin
            r_setup_cnt <= r_setup_cnt + 1'b1;
          end
        end

        WAIT_ACK_HI: begin
          if (r_ack_s) begin
            r_tx_req  <= 1'b0;
            r_tmo_cnt <= '0;
            r_state   <= WAIT_ACK_LO;
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_tx_req      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_tmo_cnt     <= '0;
            r_state       <= HOLDOFF;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        WAIT_ACK_LO: begin
          if (!r_ack_s) begin
            r_last_sent   <= r_tx_data;
            r_sent_pulse  <= 1'b1;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_tx_req      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_tmo_cnt     <= '0;
            r_state       <= HOLDOFF;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        HOLDOFF: begin
          // last_sent was not updated, so a changed word retries from IDLE.
          if (r_tmo_cnt == c_tmo_last) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        default: begin
          r_tx_req <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_req      = r_tx_req;
  assign busy        = r_busy;
  assign sent_pulse  = r_sent_pulse;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_status_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_handshake_tx
// Description : Self-checking bench for status_handshake_tx with an ack
//               responder, a transfer scoreboard and a vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_handshake_tx;

  localparam int DW = 4;
  localparam int SC = 2;
  localparam int TC = 20;
  localparam int HC = 100;
  localparam int NV = 6;

  logic          clk            = 1'b0;
  logic          internal_reset = 1'b1;
  logic [DW-1:0] status_in      = '0;
  logic          send_strobe    = 1'b0;
  logic          tx_ack         = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_req;
  logic          busy;
  logic          sent_pulse;
  logic          timeout_err;

  int            total = 0;
  int            bad   = 0;
  int            pulses = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_exp;
  logic          ack_en = 1'b1;
  logic [2:0]    req_dly = '0;
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          data_changed = 1'b0;

  typedef struct {
    logic [DW-1:0] status;
    logic          strobe;
    logic          xfer;
    logic [DW-1:0] exp_data;
  } vec_t;

  always #20 clk = ~clk;

  status_handshake_tx #(
    .DATA_WIDTH      (DW),
    .SETUP_CYCLES    (SC),
    .TIMEOUT_CYCLES  (TC),
    .HEARTBEAT_CYCLES(HC)
  ) dut (
    .clk           (clk),
    .internal_reset(internal_reset),
    .status_in     (status_in),
    .send_strobe   (send_strobe),
    .tx_data       (tx_data),
    .tx_req        (tx_req),
    .tx_ack        (tx_ack),
    .busy          (busy),
    .sent_pulse    (sent_pulse),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name, input logic val, input int limit);
    int n;
    n = 0;
    while (tx_req !== val && n < limit) begin
      tick();
      n++;
    end
    if (tx_req !== val) check(name, 32'(tx_req), 32'(val));
  endtask

  task automatic wait_pulses(input string name, input int target, input int limit);
    int n;
    n = 0;
    while (pulses < target && n < limit) begin
      tick();
      n++;
    end
    if (pulses < target) check(name, 32'(pulses), 32'(target));
  endtask

  // Pico model: ack follows tx_req three cycles later when enabled.
  always @(negedge clk) begin
    req_dly = {req_dly[1:0], tx_req};
    tx_ack  = ack_en & req_dly[2];
  end

  // Scoreboard: every sent_pulse pops the word expected for that transfer.
  always @(negedge clk) begin
    if (busy && prev_busy && tx_data !== prev_data) data_changed = 1'b1;
    prev_busy = busy;
    prev_data = tx_data;
    if (sent_pulse === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        m_exp = exp_q.pop_front();
        check("xfer_data", 32'(tx_data), 32'(m_exp));
      end
      check("data_stable_while_busy", 32'(data_changed), 32'd0);
      data_changed = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[NV];
    int   p0;
    int   n;
    logic seen_busy;

    // Starting from last_sent = 0xA after the basic transfer.
    vecs[0] = '{4'hA, 1'b0, 1'b0, 4'h0};  // no change, no strobe: nothing
    vecs[1] = '{4'hA, 1'b1, 1'b1, 4'hA};  // strobe alone resends
    vecs[2] = '{4'h5, 1'b0, 1'b1, 4'h5};  // plain change
    vecs[3] = '{4'h0, 1'b1, 1'b1, 4'h0};  // change + strobe together: one transfer
    vecs[4] = '{4'h0, 1'b0, 1'b0, 4'h0};  // settled: nothing
    vecs[5] = '{4'hF, 1'b0, 1'b1, 4'hF};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent_pulse", 32'(sent_pulse), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    internal_reset = 1'b0;

    // Basic transfer: tx_data at edge k, tx_req at k+SC
    @(negedge clk);
    status_in = 4'hA;
    exp_q.push_back(4'hA);
    tick();
    check("basic_data_k", 32'(tx_data), 32'hA);
    check("basic_req_k", 32'(tx_req), 32'd0);
    check("basic_busy_k", 32'(busy), 32'd1);
    tick();
    check("basic_req_k1", 32'(tx_req), 32'd0);
    tick();
    check("basic_req_k2", 32'(tx_req), 32'd1);
    wait_req("basic_req_fall", 1'b0, 30);
    wait_pulses("basic_pulse", 1, 30);
    repeat (5) tick();
    check("basic_one_pulse", 32'(pulses), 32'd1);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      p0 = pulses;
      status_in   = vecs[i].status;
      send_strobe = vecs[i].strobe;
      if (vecs[i].xfer) exp_q.push_back(vecs[i].exp_data);
      @(negedge clk);
      send_strobe = 1'b0;
      if (vecs[i].xfer) wait_pulses($sformatf("vec%0d_pulse", i), p0 + 1, 60);
      else repeat (30) tick();
      repeat (4) tick();
      check($sformatf("vec%0d_count", i), 32'(pulses - p0), 32'(vecs[i].xfer));
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    // Change while busy: 0x3 goes out untouched, then 0x5
    @(negedge clk);
    p0 = pulses;
    status_in = 4'h3;
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h5);
    wait_req("chg_req_rise", 1'b1, 20);
    @(negedge clk);
    status_in = 4'h5;
    tick();
    check("chg_data_held", 32'(tx_data), 32'h3);
    wait_pulses("chg_two_xfers", p0 + 2, 80);

    // Strobe collapse: three strobes during one transfer add exactly one
    repeat (5) tick();
    @(negedge clk);
    p0 = pulses;
    send_strobe = 1'b1;
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h5);
    @(negedge clk);
    send_strobe = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      send_strobe = 1'b1;
      @(negedge clk);
      send_strobe = 1'b0;
    end
    wait_pulses("strobe_pulses", p0 + 2, 80);
    repeat (40) tick();
    check("strobe_collapse_count", 32'(pulses - p0), 32'd2);

    // Timeout: no ack, req high TC cycles, holdoff TC cycles, then retry
    @(negedge clk);
    ack_en = 1'b0;
    p0 = pulses;
    status_in = 4'h9;
    exp_q.push_back(4'h9);
    wait_req("tmo_req_rise", 1'b1, 20);
    n = 1;
    tick();
    while (tx_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("tmo_req_high_cycles", 32'(n), 32'(TC));
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    check("tmo_no_pulse", 32'(pulses - p0), 32'd0);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy === 1'b1 && n < 40);
    check("tmo_holdoff_cycles", 32'(n), 32'(TC));
    check("tmo_holdoff_req_low", 32'(tx_req), 32'd0);
    ack_en = 1'b1;
    n = 0;
    while (sent_pulse !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("retry_pulse", 32'(sent_pulse), 32'd1);
    check("retry_clears_err", 32'(timeout_err), 32'd0);

    // Heartbeat: next transfer starts HC cycles after the completion edge
    exp_q.push_back(4'h9);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy !== 1'b1 && n < 200);
    check("hb_interval", 32'(n), 32'(HC));
    wait_pulses("hb_pulse", pulses + 1, 40);
    repeat (3) tick();

    // Reset in WAIT_ACK_HI: tx_req must drop without a clock edge
    @(negedge clk);
    ack_en = 1'b0;
    status_in = 4'h6;
    wait_req("rst1_req_rise", 1'b1, 20);
    @(negedge clk);
    #5 internal_reset = 1'b1;
    #1;
    check("rst1_req_async", 32'(tx_req), 32'd0);
    check("rst1_busy", 32'(busy), 32'd0);
    check("rst1_data", 32'(tx_data), 32'd0);
    status_in = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    internal_reset = 1'b0;
    ack_en = 1'b1;
    repeat (5) tick();

    // Reset in WAIT_ACK_LO: everything back to reset values, no sent_pulse
    @(negedge clk);
    p0 = pulses;
    status_in = 4'h6;
    wait_req("rst2_req_rise", 1'b1, 20);
    wait_req("rst2_req_fall", 1'b0, 20);
    @(negedge clk);
    check("rst2_in_wait_lo", 32'(busy), 32'd1);
    #5 internal_reset = 1'b1;
    #1;
    check("rst2_req", 32'(tx_req), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_data", 32'(tx_data), 32'd0);
    check("rst2_pulse", 32'(sent_pulse), 32'd0);
    check("rst2_err", 32'(timeout_err), 32'd0);
    status_in = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    internal_reset = 1'b0;
    seen_busy = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    check("rst2_no_xfer_after", 32'(seen_busy), 32'd0);
    check("rst2_no_pulse", 32'(pulses - p0), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
